// File: rtl/siso_prbs_checker.sv
// Read end of the HDSISO8 shift-register datapath.
// Measures chain depth (en-cycles of zeros on lane 0 after start), then
// self-synchronises a PRBS7 (x^7 + x^6 + 1) LFSR from lane 0 and compares
// every lane against it, counting compared steps, bit errors and lock losses.
//
// Handshake: en is a plain qualifier, not a valid/ready pair. sin is sampled
// only on a rising clk edge with en=1, and there is no back-pressure. start
// wins over en, and sin is ignored on the start cycle.
module siso_prbs_checker #(
    parameter int               LANES    = 8,
    parameter int               CNT_W    = 16,
    parameter int               LOSS_LIM = 8,
    parameter logic [LANES-1:0] INV_MASK = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             en,
    input  logic [LANES-1:0] sin,
    output logic             locked,
    output logic             timeout,
    output logic [CNT_W-1:0] depth,
    output logic [CNT_W-1:0] bit_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [7:0]       relock_cnt,
    output logic [1:0]       fsm_state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_SEED  = 2'd2,
        ST_CHECK = 2'd3
    } state_t;

    localparam int               STREAK_W = $clog2(LOSS_LIM + 1);
    localparam int               POP_W    = $clog2(LANES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_NEAR = {{(CNT_W-1){1'b1}}, 1'b0};

    state_t                state;
    state_t                state_nxt;
    logic [6:0]            lfsr;
    logic [2:0]            seed_k;
    logic [STREAK_W-1:0]   streak;
    logic                  b0;
    logic                  exp_bit;
    logic [LANES-1:0]      mismatch;
    logic [POP_W-1:0]      err_pop;
    logic [CNT_W:0]        err_sum;
    logic                  loss;

    // Lane-0 data bit, predicted PRBS bit and per-lane mismatch vector.
    assign b0       = sin[0] ^ INV_MASK[0];
    assign exp_bit  = lfsr[6] ^ lfsr[5];
    assign mismatch = sin ^ INV_MASK ^ {LANES{exp_bit}};
    assign err_sum  = {1'b0, err_cnt} + (CNT_W+1)'(err_pop);
    // This mismatch on lane 0 completes LOSS_LIM consecutive misses.
    assign loss     = mismatch[0] && (streak == STREAK_W'(LOSS_LIM - 1));

    // Count mismatching lanes for the current step.
    always_comb begin
        err_pop = '0;
        for (int i = 0; i < LANES; i++) begin
            err_pop = err_pop + POP_W'(mismatch[i]);
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: start overrides everything, otherwise advance on en.
    always_comb begin
        state_nxt = state;
        if (start) begin
            state_nxt = ST_WAIT;
        end else if (en) begin
            case (state)
                ST_WAIT:  if (b0) state_nxt = ST_SEED;
                ST_SEED:  if (seed_k == 3'd6) state_nxt = ST_CHECK;
                ST_CHECK: if (loss) state_nxt = ST_SEED;
                default:  state_nxt = state;
            endcase
        end
    end

    // Outputs decoded from the registered state.
    always_comb begin
        locked    = (state == ST_CHECK);
        fsm_state = state;
    end

    // Datapath: depth measurement, seeding, free-running compare and counters.
    always_ff @(posedge clk) begin
        if (rst || start) begin
            lfsr       <= '0;
            seed_k     <= '0;
            streak     <= '0;
            depth      <= '0;
            bit_cnt    <= '0;
            err_cnt    <= '0;
            relock_cnt <= '0;
            timeout    <= 1'b0;
        end else if (en) begin
            case (state)
                ST_WAIT: begin
                    if (!b0) begin
                        if (depth != CNT_MAX) depth <= depth + 1'b1;
                        if (depth == CNT_NEAR) timeout <= 1'b1;
                    end else begin
                        lfsr   <= {lfsr[5:0], 1'b1};
                        seed_k <= 3'd1;
                    end
                end
                ST_SEED: begin
                    lfsr   <= {lfsr[5:0], b0};
                    seed_k <= seed_k + 3'd1;
                end
                ST_CHECK: begin
                    // Received data never reloads the LFSR while locked.
                    lfsr <= {lfsr[5:0], exp_bit};
                    if (bit_cnt != CNT_MAX) bit_cnt <= bit_cnt + 1'b1;
                    err_cnt <= err_sum[CNT_W] ? CNT_MAX : err_sum[CNT_W-1:0];
                    if (loss) begin
                        streak <= '0;
                        seed_k <= '0;
                        if (relock_cnt != 8'hFF) relock_cnt <= relock_cnt + 8'd1;
                    end else begin
                        streak <= mismatch[0] ? streak + 1'b1 : '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_siso_prbs_checker.sv
// Bench for siso_prbs_checker: two instances (no inversion, and lanes 4-7
// inverted), a PRBS7 transmitter built from the stream recurrence
// x[n] = x[n-7] ^ x[n-6] and a behavioural model of the checker.
module tb_siso_prbs_checker;

    localparam int MAX      = 65535;
    localparam int LOSS_LIM = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        en;
    logic [7:0]  sin;
    logic [7:0]  sin1;

    logic        locked0, timeout0, locked1, timeout1;
    logic [15:0] depth0, bit_cnt0, err_cnt0, depth1, bit_cnt1, err_cnt1;
    logic [7:0]  relock0, relock1;
    logic [1:0]  fsm0, fsm1;

    int total = 0;
    int bad   = 0;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    siso_prbs_checker dut0 (
        .clk(clk), .rst(rst), .start(start), .en(en), .sin(sin),
        .locked(locked0), .timeout(timeout0), .depth(depth0),
        .bit_cnt(bit_cnt0), .err_cnt(err_cnt0), .relock_cnt(relock0),
        .fsm_state(fsm0)
    );

    siso_prbs_checker #(.INV_MASK(8'hF0)) dut1 (
        .clk(clk), .rst(rst), .start(start), .en(en), .sin(sin1),
        .locked(locked1), .timeout(timeout1), .depth(depth1),
        .bit_cnt(bit_cnt1), .err_cnt(err_cnt1), .relock_cnt(relock1),
        .fsm_state(fsm1)
    );

    // ---------------- transmitter ----------------
    bit tx_bits[4096];
    int tx_p = 0;

    // ---------------- reference model ----------------
    localparam int M_IDLE = 0, M_WAIT = 1, M_SEED = 2, M_CHECK = 3;
    int m_mode[2], m_depth[2], m_bit[2], m_err[2], m_relock[2], m_streak[2];
    bit m_timeout[2];
    bit hq0[$];
    bit hq1[$];

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_mode[d] = M_IDLE; m_depth[d] = 0; m_bit[d] = 0; m_err[d] = 0;
            m_relock[d] = 0; m_streak[d] = 0; m_timeout[d] = 0;
        end
        hq0.delete();
        hq1.delete();
    endtask

    // hq holds the last seven stream bits, oldest first.
    task automatic model_dut(input int d, input logic [7:0] inv, input logic st,
                             input logic e, input logic [7:0] s);
        bit hq[$];
        bit b, ex;
        logic [7:0] mis;
        if (d == 0) hq = hq0; else hq = hq1;
        if (st) begin
            m_mode[d] = M_WAIT; m_depth[d] = 0; m_bit[d] = 0; m_err[d] = 0;
            m_relock[d] = 0; m_streak[d] = 0; m_timeout[d] = 0;
            hq.delete();
        end else if (e) begin
            b = s[0] ^ inv[0];
            case (m_mode[d])
                M_WAIT: begin
                    if (!b) begin
                        if (m_depth[d] < MAX) m_depth[d]++;
                        if (m_depth[d] == MAX) m_timeout[d] = 1;
                    end else begin
                        hq.delete();
                        hq.push_back(1'b1);
                        m_mode[d] = M_SEED;
                    end
                end
                M_SEED: begin
                    hq.push_back(b);
                    if (hq.size() == 7) m_mode[d] = M_CHECK;
                end
                M_CHECK: begin
                    ex  = hq[0] ^ hq[1];
                    mis = s ^ inv ^ {8{ex}};
                    m_err[d] = m_err[d] + $countones(mis);
                    if (m_err[d] > MAX) m_err[d] = MAX;
                    if (m_bit[d] < MAX) m_bit[d]++;
                    void'(hq.pop_front());
                    hq.push_back(ex);
                    m_streak[d] = mis[0] ? m_streak[d] + 1 : 0;
                    if (m_streak[d] == LOSS_LIM) begin
                        m_mode[d] = M_SEED;
                        m_streak[d] = 0;
                        hq.delete();
                        if (m_relock[d] < 255) m_relock[d]++;
                    end
                end
                default: ;
            endcase
        end
        if (d == 0) hq0 = hq; else hq1 = hq;
    endtask

    // ---------------- driver tasks ----------------
    task automatic step(input logic st, input logic e, input logic [7:0] s, input logic [7:0] s1);
        @(negedge clk);
        start = st; en = e; sin = s; sin1 = s1;
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            model_dut(0, 8'h00, st, e, s);
            model_dut(1, 8'hF0, st, e, s1);
        end
        #1;
    endtask

    // One transmitted PRBS bit on all lanes, optionally with error flips;
    // dut1 normally receives lanes 4-7 inverted.
    task automatic tx_step(input logic [7:0] flip, input bit inv1);
        logic [7:0] w;
        if ($urandom_range(0, 3) == 0) step(1'b0, 1'b0, 8'($urandom), 8'($urandom));
        w = {8{tx_bits[tx_p]}} ^ flip;
        tx_p++;
        step(1'b0, 1'b1, w, inv1 ? (w ^ 8'hF0) : w);
    endtask

    // ---------------- scoreboard ----------------
    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".locked0"},  int'(locked0),  int'(m_mode[0] == M_CHECK));
        chk({tag, ".timeout0"}, int'(timeout0), int'(m_timeout[0]));
        chk({tag, ".depth0"},   int'(depth0),   m_depth[0]);
        chk({tag, ".bit0"},     int'(bit_cnt0), m_bit[0]);
        chk({tag, ".err0"},     int'(err_cnt0), m_err[0]);
        chk({tag, ".relock0"},  int'(relock0),  m_relock[0]);
        chk({tag, ".locked1"},  int'(locked1),  int'(m_mode[1] == M_CHECK));
        chk({tag, ".bit1"},     int'(bit_cnt1), m_bit[1]);
        chk({tag, ".err1"},     int'(err_cnt1), m_err[1]);
        chk({tag, ".relock1"},  int'(relock1),  m_relock[1]);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        for (int n = 0; n < 4096; n++) begin
            tx_bits[n] = (n < 7) ? 1'b1 : (tx_bits[n-7] ^ tx_bits[n-6]);
        end
        rst = 1'b1; start = 1'b0; en = 1'b0; sin = '0; sin1 = '0;
        model_reset();

        // 1. reset, then en with no start
        step(1'b0, 1'b1, 8'($urandom), 8'($urandom));
        step(1'b0, 1'b1, 8'($urandom), 8'($urandom));
        check_all("reset");
        chk("reset.locked", int'(locked0), 0);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'($urandom), 8'($urandom));
        check_all("idle_en");
        chk("idle_en.depth", int'(depth0), 0);

        // 2. depth 37, then lock to PRBS seeded 7'h7F
        step(1'b1, 1'b0, 8'($urandom), 8'($urandom));
        for (int i = 0; i < 37; i++) begin
            if ($urandom_range(0, 3) == 0) step(1'b0, 1'b0, 8'($urandom), 8'($urandom));
            step(1'b0, 1'b1, 8'h00, 8'h00);
        end
        chk("depth37", int'(depth0), 37);
        check_all("wait");
        for (int i = 0; i < 6; i++) tx_step(8'h00, 1'b1);
        chk("seed6.locked", int'(locked0), 0);
        tx_step(8'h00, 1'b1);
        chk("seed7.locked", int'(locked0), 1);
        chk("seed7.depth", int'(depth0), 37);
        for (int i = 0; i < 1000; i++) tx_step(8'h00, 1'b1);
        chk("clean.bit", int'(bit_cnt0), 1000);
        chk("clean.err", int'(err_cnt0), 0);
        chk("clean.err1", int'(err_cnt1), 0);
        check_all("clean");

        // 3. single and triple lane errors
        tx_step(8'h08, 1'b1);
        chk("flip3.err", int'(err_cnt0), 1);
        tx_step(8'h26, 1'b1);
        chk("flip125.err", int'(err_cnt0), 4);
        chk("flip125.locked", int'(locked0), 1);
        chk("flip125.relock", int'(relock0), 0);
        check_all("flips");

        // 4. polarity mask on dut1
        for (int i = 0; i < 20; i++) tx_step(8'h00, 1'b1);
        chk("inv.err1", int'(err_cnt1), 4);
        for (int i = 0; i < 10; i++) tx_step(8'h00, 1'b0);
        chk("noinv.err1", int'(err_cnt1), 44);
        chk("noinv.err0", int'(err_cnt0), 4);
        check_all("inv");

        // 5. loss of lock and relock
        for (int i = 0; i < LOSS_LIM - 1; i++) tx_step(8'hFF, 1'b1);
        chk("loss7.locked", int'(locked0), 1);
        tx_step(8'hFF, 1'b1);
        chk("loss.locked", int'(locked0), 0);
        chk("loss.relock", int'(relock0), 1);
        chk("loss.err", int'(err_cnt0), 4 + 8 * LOSS_LIM);
        chk("loss.bit", int'(bit_cnt0), 1032 + LOSS_LIM);
        check_all("loss");
        for (int i = 0; i < 6; i++) tx_step(8'h00, 1'b1);
        chk("relock6.locked", int'(locked0), 0);
        tx_step(8'h00, 1'b1);
        chk("relock7.locked", int'(locked0), 1);
        chk("relock7.bit", int'(bit_cnt0), 1032 + LOSS_LIM);
        check_all("relock");

        // random error injection against the model
        for (int i = 0; i < 300; i++) begin
            tx_step(($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'h00,
                    $urandom_range(0, 4) != 0);
            if (i % 50 == 49) check_all("random");
        end

        // 6. start mid-operation, en held low, timeout
        step(1'b1, 1'b1, 8'($urandom), 8'($urandom));
        chk("restart.locked", int'(locked0), 0);
        chk("restart.bit", int'(bit_cnt0), 0);
        chk("restart.err", int'(err_cnt0), 0);
        chk("restart.relock", int'(relock0), 0);
        chk("restart.state", int'(fsm0), 1);
        check_all("restart");
        for (int i = 0; i < 50; i++) step(1'b0, 1'b0, 8'($urandom), 8'($urandom));
        chk("hold.depth", int'(depth0), 0);
        check_all("hold");
        for (int i = 0; i < MAX - 1; i++) step(1'b0, 1'b1, 8'h00, 8'h00);
        chk("near.depth", int'(depth0), MAX - 1);
        chk("near.timeout", int'(timeout0), 0);
        step(1'b0, 1'b1, 8'h00, 8'h00);
        chk("sat.depth", int'(depth0), MAX);
        chk("sat.timeout", int'(timeout0), 1);
        step(1'b0, 1'b1, 8'h00, 8'h00);
        chk("sat2.depth", int'(depth0), MAX);
        check_all("sat");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
